// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit
// Description : Registered writeback stage: selects the result source, aligns
//               and extends load data, waits for slow memory reads.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OFF_WIDTH      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                mem_to_reg,
    input  logic [DATA_WIDTH-1:0]     alu_out,
    input  logic [DATA_WIDTH-1:0]     pc_plus4,
    input  logic [DATA_WIDTH-1:0]     imm,
    input  logic [2:0]                load_funct3,
    input  logic [OFF_WIDTH-1:0]      addr_off,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic                      reg_write,
    input  logic                      dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    output logic                      rd_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] rd_wr_addr,
    output logic [DATA_WIDTH-1:0]     rd_wr_data,
    output logic                      busy
);

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
    logic                      r_reg_write;
    logic [2:0]                r_funct3;
    logic [OFF_WIDTH-1:0]      r_off;

    logic                      w_is_load;
    logic                      w_complete;
    logic                      w_capture;
    logic [REG_ADDR_WIDTH-1:0] w_rd_addr;
    logic                      w_reg_write;
    logic [2:0]                w_funct3;
    logic [OFF_WIDTH-1:0]      w_off;
    logic [7:0]                w_byte;
    logic [15:0]               w_half;
    logic [31:0]               w_word;
    logic [DATA_WIDTH-1:0]     w_load_data;
    logic [DATA_WIDTH-1:0]     w_result;

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_WAIT_LOAD);
    assign w_is_load = (mem_to_reg == 2'b01);

    // In WAIT_LOAD the load's fields come from the capture registers.
    assign w_rd_addr   = busy ? r_rd_addr   : rd_addr;
    assign w_reg_write = busy ? r_reg_write : reg_write;
    assign w_funct3    = busy ? r_funct3    : load_funct3;
    assign w_off       = busy ? r_off       : addr_off;

    assign w_byte = dmem_rdata[{w_off, 3'b000} +: 8];
    assign w_half = dmem_rdata[{w_off[OFF_WIDTH-1:1], 4'b0000} +: 16];

    generate
        if (DATA_WIDTH == 64) begin : g_word64
            assign w_word = dmem_rdata[{w_off[OFF_WIDTH-1], 5'b00000} +: 32];
        end else begin : g_word32
            assign w_word = dmem_rdata[31:0];
        end
    endgenerate

    always_comb begin
        w_load_data = dmem_rdata;
        case (w_funct3)
            3'b000: w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b001: w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b100: w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            3'b101: w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            3'b010: begin
                if (DATA_WIDTH == 64) begin
                    w_load_data = {{(DATA_WIDTH-32){w_word[31]}}, w_word};
                end
            end
            3'b110: begin
                if (DATA_WIDTH == 64) begin
                    w_load_data = {{(DATA_WIDTH-32){1'b0}}, w_word};
                end
            end
            default: w_load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        w_result = alu_out;
        if (busy) begin
            w_result = w_load_data;
        end else begin
            case (mem_to_reg)
                2'b00:   w_result = alu_out;
                2'b01:   w_result = w_load_data;
                2'b10:   w_result = pc_plus4;
                default: w_result = imm;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_is_load && !dmem_rvalid) begin
                        w_capture    = 1'b1;
                        w_state_next = S_WAIT_LOAD;
                    end else begin
                        w_complete = 1'b1;
                    end
                end
            end
            S_WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    w_complete   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr   <= '0;
            r_reg_write <= 1'b0;
            r_funct3    <= '0;
            r_off       <= '0;
        end else if (w_capture) begin
            r_rd_addr   <= rd_addr;
            r_reg_write <= reg_write;
            r_funct3    <= load_funct3;
            r_off       <= addr_off;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_wr_en   <= 1'b0;
            rd_wr_addr <= '0;
            rd_wr_data <= '0;
        end else if (w_complete) begin
            rd_wr_en   <= w_reg_write && (w_rd_addr != '0);
            rd_wr_addr <= w_rd_addr;
            rd_wr_data <= w_result;
        end else begin
            rd_wr_en   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Registered, handshaked successor of the combinational writeback mux. It sits between the memory stage and the register file.
- Selects among four result sources and extracts and extends sub-word load data.
- Waits for variable-latency data-memory read responses and stalls upstream while waiting.
- Drives the register-file write port from a registered output stage.

Parameters:
- DataWidth, 32, datapath width; legal values are 32 and 64.
- RegAddrWidth, 5, register index width.
- OffWidth, 2, number of address offset bits used for load alignment; must equal log2(DataWidth/8) when DataWidth=64 (use 3).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  memory-stage result valid.
- in_ready  output  1  unit can accept a result this cycle.
- mem_to_reg  input  2  source select: 00 alu_out, 01 load data, 10 pc_plus4, 11 imm.
- alu_out  input  DataWidth  ALU result.
- pc_plus4  input  DataWidth  link value for JAL/JALR.
- imm  input  DataWidth  upper immediate for LUI.
- load_funct3  input  3  load format: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011 LD when DataWidth=64; 110 LWU when DataWidth=64.
- addr_off  input  OffWidth  low bits of the load address.
- rd_addr  input  RegAddrWidth  destination register.
- reg_write  input  1  instruction writes rd.
- dmem_rvalid  input  1  data-memory read data valid.
- dmem_rdata  input  DataWidth  raw read data, aligned to DataWidth.
- rd_wr_en  output  1  register-file write enable (single-cycle pulse).
- rd_wr_addr  output  RegAddrWidth  register-file write index.
- rd_wr_data  output  DataWidth  register-file write data.
- busy  output  1  high while in WAIT_LOAD.

Behaviour:
- Reset, while rst=1 at a clk edge:
  - state goes to IDLE.
  - rd_wr_en=0, rd_wr_addr=0, rd_wr_data=0, busy=0.
  - Any pending load is discarded; no write is issued for it.
  - rst has priority over every other event.
- State machine:
  - States are IDLE and WAIT_LOAD.
  - in_ready = (state==IDLE).
  - busy = (state==WAIT_LOAD).
- IDLE, acceptance when in_valid=1:
  - If mem_to_reg != 01, compute the result, register it, and pulse rd_wr_en on the next cycle. Latency is exactly 1 cycle.
  - If mem_to_reg == 01 and dmem_rvalid=1 in the same cycle, extract the load data immediately. Latency is 1 cycle.
  - If mem_to_reg == 01 and dmem_rvalid=0, capture rd_addr, reg_write, load_funct3 and addr_off, then move to WAIT_LOAD.
- WAIT_LOAD:
  - in_ready=0; in_valid is ignored.
  - On dmem_rvalid=1, extract the load data from the captured fields. rd_wr_en pulses on the next cycle and state returns to IDLE.
  - A new result is accepted no earlier than the cycle after the return to IDLE.
  - There is no timeout; the unit waits indefinitely.
- dmem_rvalid while in IDLE with no load being accepted is ignored.
- Write enable:
  - rd_wr_en = captured reg_write AND (captured rd_addr != 0). Writes to x0 are suppressed.
  - When rd_wr_en is suppressed, rd_wr_addr and rd_wr_data still update.
  - In cycles with no completion, rd_wr_en=0 and rd_wr_addr/rd_wr_data hold their last values.
- Load extraction:
  - Byte select = addr_off.
  - Halfword select = addr_off with bit 0 ignored.
  - Word select (64-bit only) = addr_off[2].
  - Signed formats sign-extend from the selected field's MSB to DataWidth; unsigned formats zero-extend.
  - LW on DataWidth=32 passes all 32 bits.
  - Unlisted funct3 codes pass dmem_rdata unmodified.
- Sources 00, 10 and 11 pass through unmodified.
- Throughput: one result per cycle when no load waits.

Test Plan:
- ALU path: reset, then in_valid=1, mem_to_reg=00, alu_out=0x0000_1234, rd_addr=5, reg_write=1 -> next cycle rd_wr_en=1, rd_wr_addr=5, rd_wr_data=0x0000_1234. The following cycle rd_wr_en=0.
- Zero-latency LB: mem_to_reg=01, funct3=000, addr_off=2, dmem_rvalid=1, dmem_rdata=0x1280_FF00 -> rd_wr_data=0xFFFF_FF80 one cycle later. Repeating with funct3=100 (LBU) -> 0x0000_0080.
- Delayed LH: funct3=001, addr_off=2, dmem_rvalid held 0 for 3 cycles, then 1 with rdata=0x8001_0000:
  - in_ready=0 and busy=1 for the 3 wait cycles plus the response cycle.
  - A concurrent in_valid in that window is ignored.
  - rd_wr_data=0xFFFF_8001 the cycle after the response.
- x0 suppression and sources:
  - rd_addr=0, mem_to_reg=10, pc_plus4=0x104 -> rd_wr_en stays 0.
  - Then mem_to_reg=11, imm=0xABCD_E000, rd_addr=7 -> rd_wr_data=0xABCD_E000 with rd_wr_en=1.
- Reset mid-load: enter WAIT_LOAD, assert rst for one cycle, then drive dmem_rvalid=1 -> no rd_wr_en pulse; state is IDLE and in_ready=1.
- Back-to-back: 4 consecutive ALU results (values 1,2,3,4; rd 1..4) -> rd_wr_en high for 4 consecutive cycles with matching data and addresses.
